// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO; results land a fixed latency after issue.
// Optional `MULDIV_MADD_EN enables madd/maddu/msub/msubu (ops 6-9).
module muldiv_unit #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        stall_req
);

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MTHI  = 4'd4,
        OP_MTLO  = 4'd5,
        OP_MADD  = 4'd6,
        OP_MADDU = 4'd7,
        OP_MSUB  = 4'd8,
        OP_MSUBU = 4'd9
    } op_e;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

    logic [3:0]  cnt;
    logic [31:0] p_hi, p_lo;
    logic        accept, is_long, is_div;
    logic [63:0] result;
    logic [63:0] prod_s, prod_u;
    logic [31:0] div_b;
    logic signed [31:0] q_s, r_s;
    logic [31:0] q_u, r_u;

    assign accept = start & ~req & ~busy;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Divisor forced to 1 when zero so the datapath never produces X; the result is discarded anyway.
    assign div_b = (B == '0) ? 32'd1 : B;
    assign q_s   = $signed(A) / $signed(div_b);
    assign r_s   = $signed(A) % $signed(div_b);
    assign q_u   = A / div_b;
    assign r_u   = A % div_b;

    always_comb begin
        result  = {HI, LO};
        is_long = 1'b0;
        is_div  = 1'b0;
        case (op)
            OP_MULT:  begin is_long = 1'b1; result = prod_s; end
            OP_MULTU: begin is_long = 1'b1; result = prod_u; end
            OP_DIV: begin
                is_long = 1'b1;
                is_div  = 1'b1;
                if (B != '0) result = {r_s, q_s};
            end
            OP_DIVU: begin
                is_long = 1'b1;
                is_div  = 1'b1;
                if (B != '0) result = {r_u, q_u};
            end
`ifdef MULDIV_MADD_EN
            OP_MADD:  begin is_long = 1'b1; result = {HI, LO} + prod_s; end
            OP_MADDU: begin is_long = 1'b1; result = {HI, LO} + prod_u; end
            OP_MSUB:  begin is_long = 1'b1; result = {HI, LO} - prod_s; end
            OP_MSUBU: begin is_long = 1'b1; result = {HI, LO} - prod_u; end
`endif
            default: ;
        endcase
    end

    assign stall_req = (accept & is_long) | busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            HI   <= '0;
            LO   <= '0;
            p_hi <= '0;
            p_lo <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (cnt != '0) begin
            cnt  <= cnt - 4'd1;
            busy <= (cnt != 4'd1);
            if (cnt == 4'd1) begin
                HI <= p_hi;
                LO <= p_lo;
            end
        end else if (accept) begin
            if (op == OP_MTHI) begin
                HI <= A;
            end else if (op == OP_MTLO) begin
                LO <= A;
            end else if (is_long) begin
                {p_hi, p_lo} <= result;
                cnt          <= is_div ? DIV_LOAD : MUL_LOAD;
                busy         <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latencies, results, flush, ignore-while-busy, reset.
// Madd expectations follow `MULDIV_MADD_EN.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A, B;
    logic        req;
    logic [31:0] HI, LO;
    logic        busy, stall_req;

    int n_checks = 0;
    int n_fail   = 0;
    int n;

    muldiv_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .A         (A),
        .B         (B),
        .req       (req),
        .HI        (HI),
        .LO        (LO),
        .busy      (busy),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start cycle, check the combinational stall, then drop start.
    task automatic issue(input string tag, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic r, input logic exp_stall);
        start = 1'b1; op = o; A = a; B = b; req = r;
        #1;
        check({tag, "_stall"}, 64'(stall_req), 64'(exp_stall));
        tick();
        start = 1'b0; req = 1'b0;
    endtask

    // Count busy cycles until idle, bounded.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 40) begin
            cycles++;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; op = '0; A = '0; B = '0; req = 1'b0;
        tick(); tick();
        check("rst_hi", 64'(HI), 64'h0);
        check("rst_lo", 64'(LO), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        reset_n = 1'b1;
        tick();

        issue("mult", 4'd0, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b1);
        wait_idle(n);
        check("mult_lat", 64'(n), 64'd5);
        check("mult_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFFE);

        issue("multu", 4'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b1);
        wait_idle(n);
        check("multu_lat", 64'(n), 64'd5);
        check("multu_hilo", {HI, LO}, 64'h00000001_FFFFFFFE);

        issue("mult_neg", 4'd0, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b1);
        wait_idle(n);
        check("mult_neg_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFF1);

        issue("div", 4'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
        wait_idle(n);
        check("div_lat", 64'(n), 64'd10);
        check("div_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);

        issue("div_negb", 4'd2, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b1);
        wait_idle(n);
        check("div_negb_hilo", {HI, LO}, 64'h00000001_FFFFFFFD);

        issue("divu0", 4'd3, 32'd7, 32'd0, 1'b0, 1'b1);
        wait_idle(n);
        check("divu0_lat", 64'(n), 64'd10);
        check("divu0_hilo", {HI, LO}, 64'h00000001_FFFFFFFD);

        issue("divu", 4'd3, 32'd100, 32'd7, 1'b0, 1'b1);
        wait_idle(n);
        check("divu_hilo", {HI, LO}, 64'h00000002_0000000E);

        issue("mthi", 4'd4, 32'h12345678, 32'd0, 1'b0, 1'b0);
        check("mthi_hi", 64'(HI), 64'h12345678);
        check("mthi_busy", 64'(busy), 64'h0);

        issue("mthi_req", 4'd4, 32'hDEADBEEF, 32'd0, 1'b1, 1'b0);
        check("mthi_req_hi", 64'(HI), 64'h12345678);

        issue("mult_req", 4'd0, 32'd3, 32'd4, 1'b1, 1'b0);
        check("mult_req_busy", 64'(busy), 64'h0);
        check("mult_req_hilo", {HI, LO}, 64'h12345678_0000000E);

        // mult at T; mtlo attempted at T+2 must be ignored; result lands at T+6.
        issue("mult_b2b", 4'd0, 32'd3, 32'd4, 1'b0, 1'b1);
        tick();
        issue("mtlo_busy", 4'd5, 32'h0000AAAA, 32'd0, 1'b0, 1'b1);
        check("mtlo_busy_lo", 64'(LO), 64'h0000000E);
        tick(); tick();
        check("b2b_t5_busy", 64'(busy), 64'h1);
        tick();
        check("b2b_t6_busy", 64'(busy), 64'h0);
        check("b2b_t6_hilo", {HI, LO}, 64'h00000000_0000000C);
        issue("mtlo_t6", 4'd5, 32'h00000055, 32'd0, 1'b0, 1'b0);
        check("mtlo_t6_lo", 64'(LO), 64'h00000055);

        // Reset pulsed mid-divide discards the in-flight result.
        issue("div_rst", 4'd2, 32'd100, 32'd7, 1'b0, 1'b1);
        tick(); tick();
        reset_n = 1'b0;
        #1;
        check("rst_mid_hilo", {HI, LO}, 64'h0);
        check("rst_mid_busy", 64'(busy), 64'h0);
        tick();
        reset_n = 1'b1;
        tick();
        check("rst_after_busy", 64'(busy), 64'h0);
        issue("mult_post", 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
        wait_idle(n);
        check("mult_post_lat", 64'(n), 64'd5);
        check("mult_post_hilo", {HI, LO}, 64'h00000000_00000001);

        issue("op_unused", 4'd12, 32'd9, 32'd9, 1'b0, 1'b0);
        check("op_unused_busy", 64'(busy), 64'h0);

        issue("mthi0", 4'd4, 32'd0, 32'd0, 1'b0, 1'b0);
        issue("mtlo_ff", 4'd5, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0);
`ifdef MULDIV_MADD_EN
        issue("maddu", 4'd7, 32'd1, 32'd1, 1'b0, 1'b1);
        wait_idle(n);
        check("maddu_lat", 64'(n), 64'd5);
        check("maddu_hilo", {HI, LO}, 64'h00000001_00000000);
        issue("msub", 4'd8, 32'hFFFFFFFF, 32'd3, 1'b0, 1'b1);
        wait_idle(n);
        check("msub_hilo", {HI, LO}, 64'h00000001_00000003);
`else
        issue("maddu", 4'd7, 32'd1, 32'd1, 1'b0, 1'b0);
        check("maddu_busy", 64'(busy), 64'h0);
        check("maddu_hilo", {HI, LO}, 64'h00000000_FFFFFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the P7 pipeline. It sits in EX beside the ALU and owns the HI/LO registers. It executes mult/multu/div/divu/mthi/mtlo issued from EX, and it is the source of the `busy` signal that the hazard solver consumes to stall muldiv-class instructions in ID. Results appear in HI/LO a fixed number of cycles after issue; mfhi/mflo read HI/LO directly.

## Interface
Parameters:
- `MUL_CYCLES`, 5, busy cycles for mult/multu (and madd family); must be ≥1
- `DIV_CYCLES`, 10, busy cycles for div/divu; must be ≥1

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  muldiv instruction valid in EX this cycle
- `op`  in  4  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu, 8 msub, 9 msubu, others no-op
- `A`  in  32  rs operand (forwarded)
- `B`  in  32  rt operand (forwarded)
- `req`  in  1  exception/interrupt being taken this cycle; EX instruction is flushed
- `HI`  out  32  HI register
- `LO`  out  32  LO register
- `busy`  out  1  registered; high while an operation is in flight
- `stall_req`  out  1  combinational `accepted_start_of_a_busy_op | busy`; the hazard solver uses it

## Operation
- Accept condition: `start & ~req & ~busy`. An accepted mthi or mtlo writes `A` to HI or LO at that edge and does not assert `busy`.
- Accepted mult/div/madd-family operation:
  - Latch the computed result into pending registers `pHI`/`pLO`.
  - Load the counter with MUL_CYCLES or DIV_CYCLES.
- Counter is 4 bits wide (holds DIV_CYCLES). `busy = (cnt != 0)`.
  - Each cycle with cnt≠0: cnt decrements.
  - On the edge where cnt goes 1→0: HI←pHI, LO←pLO.
- mult: signed 64-bit product; {HI,LO} = A*B.
- multu: unsigned 64-bit product; {HI,LO} = A*B.
- div/divu: LO = quotient, HI = remainder. Signed division truncates toward zero, and the remainder takes the sign of the dividend.
- Divide by zero (B=0): the full DIV_CYCLES busy period still elapses. HI/LO keep their previous values.
- `start` while busy: ignored, with no effect on the counter, pending registers, or HI/LO. The hazard solver guarantees this does not occur.
- `req` high together with `start`: the operation is not accepted. An operation already in flight is not cancelled by `req` and completes normally.
- Unused op codes, and op 6–9 when compiled out: no-op.
- Reset (any time, including mid-operation):
  - HI=0, LO=0, pHI=0, pLO=0, cnt=0.
  - busy=0; the in-flight result is discarded.

## Timing
- Issue cycle T = the accepted `start` cycle.
- `busy` is high in cycles T+1 … T+L, where L is the latency.
- New HI/LO values are visible from cycle T+L+1, the same cycle `busy` falls.
- `stall_req` is high from T (combinational via `start`) through T+L.
- mthi/mtlo: the new value is visible in T+1.
- mfhi/mflo read in any cycle returns current HI/LO with zero latency. No internal bypass of pending results exists; the stall covers that case.
- Back-to-back: the next operation can be accepted in T+L+1.

## Configuration
- `MULDIV_MADD_EN` defined: op 6–9 enabled, each with latency MUL_CYCLES.
  - madd (signed) / maddu (unsigned): {HI,LO} = {HI,LO} + A*B.
  - msub (signed) / msubu (unsigned): {HI,LO} = {HI,LO} − A*B.
  - {HI,LO} is the value at issue; arithmetic is 64-bit modulo.
- Not defined: op 6–9 are no-ops. They do not assert busy or stall_req, and do not write HI/LO.

## Test plan
- mult A=0xFFFFFFFF, B=2 → busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu on the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7), B=2 → busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 → busy 10 cycles, HI/LO unchanged.
- mthi A=0x12345678 with req=0 → HI=0x12345678 next cycle, busy stays 0. Same with req=1 → HI unchanged. mult with req=1 → busy stays 0.
- mult accepted, then start=1 with op=mtlo at T+2 → ignored, and the mult result lands at T+6. mtlo issued at T+6 → accepted.
- reset_n pulsed low at T+3 of a div → HI=LO=0 and busy=0 immediately. After release the unit accepts a new mult normally.
- With MULDIV_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu A=1, B=1 → HI=1, LO=0 after 5 cycles. Without the macro, the same stimulus leaves busy=0 and HI/LO unchanged.
